cim_step_scheduler: RTL and testbench
=====================================

# cim_step_scheduler

Time-step sequencer and mode arbiter for one CIM macro. Accepts 256-bit spike frames from the upstream spike router, runs a host-programmed number of inference time steps on the macro (EN/FT/SPIKE_REMAP sequencing), captures each step's 16 neuron outputs, accumulates per-neuron spike counts, and grants the macro to the memory-mode programmer only while inference is idle.

## Interface
- STEP_W, 8, width of time-step count
- CNT_W, 8, width of each per-neuron spike counter
- TO_CYC, 8, REQ timeout in cycles after EN

- CLK  in  1  clock
- RSTB  in  1  reset, asynchronous, active-low
- START  in  1  start inference run (sampled in IDLE only)
- NUM_STEPS  in  STEP_W  time steps per run; 0 treated as 1
- BUSY  out  1  high in FETCH/FIRE/WAIT
- DONE  out  1  one-cycle pulse at end of successful run
- ERR  out  1  sticky timeout flag; cleared on accepted START
- SPK_VALID  in  1  spike frame valid
- SPK_READY  out  1  scheduler ready for frame
- SPK_DATA  in  256  spike frame
- EN  out  1  macro compute enable
- FT  out  1  macro first-time-step flag
- SPIKE_REMAP  out  256  spike frame to macro
- PD  out  1  macro power-down
- REQ  in  1  macro output request
- NEURON_OUT  in  16  macro neuron outputs
- OUT_VALID  out  1  one-cycle pulse, OUT_SPIKES valid
- OUT_SPIKES  out  16  captured neuron outputs of a step
- CNT_SEL  in  4  counter readback select
- CNT_DATA  out  CNT_W  spike count of neuron CNT_SEL (combinational mux)
- MS_REQ  in  1  memory-mode access request
- MS_GNT  out  1  memory-mode grant
- MS  out  1  macro mode select

## Operation
- States: IDLE, FETCH, FIRE, WAIT, MEM.
- IDLE: PD=1. START=1 -> latch T=max(NUM_STEPS,1), step=0, clear all counters and ERR, -> FETCH. Else MS_REQ=1 -> MEM. START has priority over MS_REQ when both high.
- FETCH: SPK_READY=1, PD=0. On SPK_VALID&SPK_READY: SPIKE_REMAP<=SPK_DATA, -> FIRE.
- FIRE (exactly one cycle): EN=1, FT=(step==0). -> WAIT, timeout counter cleared.
- WAIT: on REQ=1: OUT_SPIKES<=NEURON_OUT, OUT_VALID pulse next cycle; counter[i]+=NEURON_OUT[i], saturating at 2^CNT_W-1; step+=1; if step+1==T -> IDLE with DONE, else -> FETCH. If TO_CYC cycles elapse without REQ: ERR<=1, -> IDLE, no DONE, no OUT_VALID.
- MEM: MS=1, MS_GNT=1, PD=1, while MS_REQ=1; MS_REQ=0 -> IDLE. START ignored (not queued) in MEM and in busy states.
- REQ outside WAIT ignored. SPIKE_REMAP held constant from FIRE until next frame handshake.
- Counters hold after run for readback until next accepted START.

## Timing
- All outputs registered except CNT_DATA. Reset values: BUSY, DONE, ERR, SPK_READY, EN, FT, OUT_VALID, MS_GNT, MS = 0; SPIKE_REMAP, OUT_SPIKES, counters = 0; PD=1; state IDLE.
- START accepted at edge N -> SPK_READY high cycle N+1.
- Handshake at edge H -> EN/FT high cycle H+1 only.
- Macro returns REQ in cycle E+3 (E = EN cycle); TO_CYC counts cycles E+1..E+TO_CYC.
- REQ sampled at edge R -> OUT_VALID, OUT_SPIKES, updated counters visible cycle R+1; DONE coincides with last OUT_VALID; SPK_READY for next step high cycle R+1.
- Minimum step period with SPK_VALID held high: 5 cycles.
- MS_REQ sampled in IDLE at edge M -> MS/MS_GNT high from cycle M+1; deassert seen at edge D -> MS/MS_GNT low cycle D+1, PD stays 1.
- Asynchronous reset mid-run: immediate return to reset values; in-flight step discarded.

## Test plan
- NUM_STEPS=3, frames always valid, model REQ at E+3 with NEURON_OUT=16'h0005 -> FT high only on first EN, 3 OUT_VALID pulses 5 cycles apart, DONE with third, counters 0 and 2 read 3, others 0.
- NUM_STEPS=0 -> exactly one EN with FT=1, one OUT_VALID, DONE.
- Counter saturation, CNT_W=2, NUM_STEPS=5, NEURON_OUT=16'hFFFF -> all counters read 3.
- Withhold REQ after EN -> ERR=1 at cycle E+9, state IDLE, no DONE; next START clears ERR.
- MS_REQ and START same cycle in IDLE -> run starts, MS_GNT stays 0; MS_REQ still high after DONE -> MS/MS_GNT high 2 cycles after DONE cycle; START during MEM ignored.
- SPK_VALID gapped 10 cycles between steps -> EN waits for handshake; RSTB low during WAIT -> all outputs at reset values immediately, PD=1.

Source files
------------

// File: rtl/cim_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cim_step_scheduler
// Brief    : Time-step sequencer and mode arbiter for one CIM macro. Feeds
//            spike frames, runs EN/FT steps, captures and counts neuron
//            spikes, and grants the macro to memory mode while idle.
// Revision : 1.0 - initial release
// ============================================================================
module cim_step_scheduler #(
    parameter int STEP_W = 8,
    parameter int CNT_W  = 8,
    parameter int TO_CYC = 8
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               START,
    input  logic [STEP_W-1:0]  NUM_STEPS,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    input  logic               SPK_VALID,
    output logic               SPK_READY,
    input  logic [255:0]       SPK_DATA,
    output logic               EN,
    output logic               FT,
    output logic [255:0]       SPIKE_REMAP,
    output logic               PD,
    input  logic               REQ,
    input  logic [15:0]        NEURON_OUT,
    output logic               OUT_VALID,
    output logic [15:0]        OUT_SPIKES,
    input  logic [3:0]         CNT_SEL,
    output logic [CNT_W-1:0]   CNT_DATA,
    input  logic               MS_REQ,
    output logic               MS_GNT,
    output logic               MS
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_FIRE  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_MEM   = 3'd4;

    localparam int                 c_TO_W    = $clog2(TO_CYC + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [STEP_W-1:0]  r_step;
    logic [STEP_W-1:0]  r_t;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0]   r_cnt [16];

    logic               w_start_ok;
    logic               w_handshake;
    logic               w_req_ok;
    logic               w_timeout;
    logic               w_last;
    logic [STEP_W:0]    w_step_inc;

    assign w_step_inc = {1'b0, r_step} + {{STEP_W{1'b0}}, 1'b1};
    assign w_last     = (w_step_inc == {1'b0, r_t});
    assign CNT_DATA   = r_cnt[CNT_SEL];

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_handshake = 1'b0;
        w_req_ok    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (START) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = c_ST_FETCH;
                end else if (MS_REQ) begin
                    w_state_nxt = c_ST_MEM;
                end
            end
            c_ST_FETCH: begin
                if (SPK_VALID && SPK_READY) begin
                    w_handshake = 1'b1;
                    w_state_nxt = c_ST_FIRE;
                end
            end
            c_ST_FIRE: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // A REQ on the final timeout cycle still wins over the timeout.
                if (REQ) begin
                    w_req_ok    = 1'b1;
                    w_state_nxt = w_last ? c_ST_IDLE : c_ST_FETCH;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_MEM: begin
                if (!MS_REQ) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state     <= c_ST_IDLE;
            r_step      <= '0;
            r_t         <= '0;
            r_to_cnt    <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            SPK_READY   <= 1'b0;
            EN          <= 1'b0;
            FT          <= 1'b0;
            SPIKE_REMAP <= '0;
            PD          <= 1'b1;
            OUT_VALID   <= 1'b0;
            OUT_SPIKES  <= '0;
            MS_GNT      <= 1'b0;
            MS          <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            BUSY      <= (w_state_nxt == c_ST_FETCH) || (w_state_nxt == c_ST_FIRE) ||
                         (w_state_nxt == c_ST_WAIT);
            SPK_READY <= (w_state_nxt == c_ST_FETCH);
            EN        <= (w_state_nxt == c_ST_FIRE);
            FT        <= (w_state_nxt == c_ST_FIRE) && (r_step == '0);
            PD        <= (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_MEM);
            MS        <= (w_state_nxt == c_ST_MEM);
            MS_GNT    <= (w_state_nxt == c_ST_MEM);
            DONE      <= w_req_ok && w_last;
            OUT_VALID <= w_req_ok;
            r_to_cnt  <= (r_state == c_ST_WAIT) ? r_to_cnt + c_TO_W'(1) : '0;

            if (w_start_ok) begin
                r_t    <= (NUM_STEPS == '0) ? STEP_W'(1) : NUM_STEPS;
                r_step <= '0;
                ERR    <= 1'b0;
                for (int i = 0; i < 16; i++) begin
                    r_cnt[i] <= '0;
                end
            end

            if (w_timeout) begin
                ERR <= 1'b1;
            end

            if (w_handshake) begin
                SPIKE_REMAP <= SPK_DATA;
            end

            if (w_req_ok) begin
                OUT_SPIKES <= NEURON_OUT;
                r_step     <= w_step_inc[STEP_W-1:0];
                for (int i = 0; i < 16; i++) begin
                    if (NEURON_OUT[i] && (r_cnt[i] != c_CNT_MAX)) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cim_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cim_step_scheduler
// Brief    : Directed self-checking bench for cim_step_scheduler with a
//            small macro model answering REQ three cycles after EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cim_step_scheduler;

    logic          CLK;
    logic          RSTB;
    logic          START;
    logic [7:0]    NUM_STEPS;
    logic          SPK_VALID;
    logic [255:0]  SPK_DATA;
    logic          REQ;
    logic [15:0]   NEURON_OUT;
    logic [3:0]    CNT_SEL;
    logic          MS_REQ;

    logic          BUSY, DONE, ERR, SPK_READY, EN, FT, PD, OUT_VALID, MS_GNT, MS;
    logic [255:0]  SPIKE_REMAP;
    logic [15:0]   OUT_SPIKES;
    logic [7:0]    CNT_DATA;

    logic          s_busy, s_done, s_err, s_spk_ready, s_en, s_ft, s_pd, s_ov, s_gnt, s_ms;
    logic [255:0]  s_remap;
    logic [15:0]   s_out_spikes;
    logic [1:0]    s_cnt_data;

    cim_step_scheduler u_dut (
        .CLK(CLK), .RSTB(RSTB), .START(START), .NUM_STEPS(NUM_STEPS),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .SPK_VALID(SPK_VALID), .SPK_READY(SPK_READY), .SPK_DATA(SPK_DATA),
        .EN(EN), .FT(FT), .SPIKE_REMAP(SPIKE_REMAP), .PD(PD),
        .REQ(REQ), .NEURON_OUT(NEURON_OUT),
        .OUT_VALID(OUT_VALID), .OUT_SPIKES(OUT_SPIKES),
        .CNT_SEL(CNT_SEL), .CNT_DATA(CNT_DATA),
        .MS_REQ(MS_REQ), .MS_GNT(MS_GNT), .MS(MS)
    );

    // Narrow-counter instance shares all stimulus; only its counters are checked.
    cim_step_scheduler #(.CNT_W(2)) u_dut_sat (
        .CLK(CLK), .RSTB(RSTB), .START(START), .NUM_STEPS(NUM_STEPS),
        .BUSY(s_busy), .DONE(s_done), .ERR(s_err),
        .SPK_VALID(SPK_VALID), .SPK_READY(s_spk_ready), .SPK_DATA(SPK_DATA),
        .EN(s_en), .FT(s_ft), .SPIKE_REMAP(s_remap), .PD(s_pd),
        .REQ(REQ), .NEURON_OUT(NEURON_OUT),
        .OUT_VALID(s_ov), .OUT_SPIKES(s_out_spikes),
        .CNT_SEL(CNT_SEL), .CNT_DATA(s_cnt_data),
        .MS_REQ(MS_REQ), .MS_GNT(s_gnt), .MS(s_ms)
    );

    int           total = 0;
    int           bad   = 0;
    int           cyc;
    int           n_en, n_ft, n_ft_alone, n_ov, n_done, n_gnt, done_cyc;
    int           ov_cyc[$];
    logic         model_en;
    logic [15:0]  model_val;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Macro model: REQ for one cycle in cycle E+3.
    initial begin
        REQ        = 1'b0;
        NEURON_OUT = '0;
        forever begin
            @(posedge CLK); #1;
            if (EN && model_en) begin
                repeat (3) begin
                    @(posedge CLK); #1;
                end
                REQ        = 1'b1;
                NEURON_OUT = model_val;
                @(posedge CLK); #1;
                REQ        = 1'b0;
                NEURON_OUT = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_en = 0; n_ft = 0; n_ft_alone = 0; n_ov = 0; n_done = 0;
        n_gnt = 0; done_cyc = -1;
        ov_cyc.delete();
    endtask

    task automatic tick();
        @(posedge CLK); #1;
        cyc++;
        if (EN) n_en++;
        if (EN && FT) n_ft++;
        if (FT && !EN) n_ft_alone++;
        if (MS_GNT) n_gnt++;
        if (OUT_VALID) begin
            n_ov++;
            ov_cyc.push_back(cyc);
        end
        if (DONE) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RSTB = 1'b0; START = 1'b0; NUM_STEPS = '0; SPK_VALID = 1'b0; SPK_DATA = '0;
        CNT_SEL = '0; MS_REQ = 1'b0; model_en = 1'b1; model_val = 16'h0005;
        clr();

        // Reset values
        ticks(2);
        chk("rst_pd", PD, 1'b1);
        chk("rst_flags", {BUSY, DONE, ERR, SPK_READY, EN, FT, OUT_VALID, MS_GNT, MS}, 9'd0);
        chk("rst_remap", SPIKE_REMAP, 256'd0);
        chk("rst_out", OUT_SPIKES, 16'd0);
        chk("rst_cnt", CNT_DATA, 8'd0);
        RSTB = 1'b1;
        ticks(2);

        // Three-step run, frames always valid
        clr();
        NUM_STEPS = 8'd3; SPK_VALID = 1'b1; SPK_DATA = {8{32'hA5A5_0001}}; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t1_ready_n1", SPK_READY, 1'b1);
        chk("t1_pd_run", PD, 1'b0);
        tick();
        chk("t1_en_first", {EN, FT}, 2'b11);
        chk("t1_remap", SPIKE_REMAP, {8{32'hA5A5_0001}});
        ticks(16);
        chk("t1_n_en", n_en, 3);
        chk("t1_n_ft", n_ft, 1);
        chk("t1_ft_alone", n_ft_alone, 0);
        chk("t1_n_ov", n_ov, 3);
        chk("t1_ov0", ov_cyc.size() > 0 ? ov_cyc[0] : -1, 6);
        chk("t1_ov1", ov_cyc.size() > 1 ? ov_cyc[1] : -1, 11);
        chk("t1_ov2", ov_cyc.size() > 2 ? ov_cyc[2] : -1, 16);
        chk("t1_done_cyc", done_cyc, 16);
        chk("t1_n_done", n_done, 1);
        chk("t1_out", OUT_SPIKES, 16'h0005);
        chk("t1_idle", {BUSY, PD, ERR}, 3'b010);
        CNT_SEL = 4'd0; #1 chk("t1_cnt0", CNT_DATA, 8'd3);
        CNT_SEL = 4'd2; #1 chk("t1_cnt2", CNT_DATA, 8'd3);
        CNT_SEL = 4'd1; #1 chk("t1_cnt1", CNT_DATA, 8'd0);
        CNT_SEL = 4'd15; #1 chk("t1_cnt15", CNT_DATA, 8'd0);

        // NUM_STEPS=0 runs a single step
        clr();
        NUM_STEPS = 8'd0; START = 1'b1;
        tick();
        START = 1'b0;
        ticks(11);
        chk("t2_n_en", n_en, 1);
        chk("t2_n_ft", n_ft, 1);
        chk("t2_n_ov", n_ov, 1);
        chk("t2_done_cyc", done_cyc, 6);
        CNT_SEL = 4'd0; #1 chk("t2_cnt0", CNT_DATA, 8'd1);

        // Saturation: CNT_W=2 instance pins at 3, 8-bit instance counts to 5
        clr();
        model_val = 16'hFFFF; NUM_STEPS = 8'd5; START = 1'b1;
        tick();
        START = 1'b0;
        ticks(27);
        chk("t3_n_ov", n_ov, 5);
        chk("t3_done_cyc", done_cyc, 26);
        CNT_SEL = 4'd0; #1 chk("t3_sat0", s_cnt_data, 2'd3);
        CNT_SEL = 4'd9; #1 chk("t3_sat9", s_cnt_data, 2'd3);
        CNT_SEL = 4'd15; #1 chk("t3_sat15", s_cnt_data, 2'd3);
        CNT_SEL = 4'd7; #1 chk("t3_wide7", CNT_DATA, 8'd5);

        // Timeout: REQ withheld
        clr();
        model_en = 1'b0; NUM_STEPS = 8'd2; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("t4_en", EN, 1'b1);
        ticks(8);
        chk("t4_err_early", {ERR, BUSY}, 2'b01);
        tick();
        chk("t4_err_set", ERR, 1'b1);
        chk("t4_idle", {BUSY, PD}, 2'b01);
        chk("t4_no_done", n_done, 0);
        chk("t4_no_ov", n_ov, 0);
        ticks(2);
        chk("t4_err_sticky", ERR, 1'b1);
        clr();
        model_en = 1'b1; model_val = 16'h0005; NUM_STEPS = 8'd1; START = 1'b1;
        tick();
        START = 1'b0;
        chk("t4_err_clr", ERR, 1'b0);
        ticks(7);
        chk("t4_rerun_done", n_done, 1);

        // START and MS_REQ together, then MEM entry and exit
        clr();
        NUM_STEPS = 8'd1; START = 1'b1; MS_REQ = 1'b1;
        tick();
        START = 1'b0;
        chk("t5_start_wins", {BUSY, MS_GNT}, 2'b10);
        ticks(5);
        chk("t5_done_cyc", done_cyc, 6);
        chk("t5_no_gnt_run", n_gnt, 0);
        chk("t5_ms_at_done", MS, 1'b0);
        ticks(2);
        chk("t5_mem", {MS, MS_GNT, PD}, 3'b111);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("t5_start_ign", {BUSY, SPK_READY, MS_GNT}, 3'b001);
        MS_REQ = 1'b0;
        tick();
        chk("t5_mem_exit", {MS, MS_GNT, PD}, 3'b001);
        ticks(2);
        chk("t5_not_queued", {BUSY, SPK_READY}, 2'b00);

        // Gapped frames, then asynchronous reset during WAIT
        clr();
        model_val = 16'h8001; NUM_STEPS = 8'd2; SPK_VALID = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        ticks(10);
        chk("t6_no_en_gap", n_en, 0);
        chk("t6_ready_hold", SPK_READY, 1'b1);
        SPK_VALID = 1'b1; SPK_DATA = {16{16'hBEEF}};
        tick();
        SPK_VALID = 1'b0;
        chk("t6_en", {EN, FT}, 2'b11);
        ticks(4);
        chk("t6_ov", {OUT_VALID, SPK_READY}, 2'b11);
        chk("t6_out", OUT_SPIKES, 16'h8001);
        chk("t6_remap_hold", SPIKE_REMAP, {16{16'hBEEF}});
        CNT_SEL = 4'd15; #1 chk("t6_cnt15", CNT_DATA, 8'd1);
        SPK_VALID = 1'b1; SPK_DATA = {32{8'h3C}};
        tick();
        SPK_VALID = 1'b0;
        chk("t6_en2", {EN, FT}, 2'b10);
        chk("t6_remap2", SPIKE_REMAP, {32{8'h3C}});
        ticks(2);
        RSTB = 1'b0;
        #1;
        chk("t6_rst_pd", PD, 1'b1);
        chk("t6_rst_flags", {BUSY, DONE, ERR, SPK_READY, EN, FT, OUT_VALID, MS_GNT, MS}, 9'd0);
        chk("t6_rst_remap", SPIKE_REMAP, 256'd0);
        chk("t6_rst_out", OUT_SPIKES, 16'd0);
        chk("t6_rst_cnt", CNT_DATA, 8'd0);
        ticks(2);
        RSTB = 1'b1;
        ticks(3);
        chk("t6_after_rst", {BUSY, PD}, 2'b01);
        chk("t6_no_done", n_done, 0);
        chk("t6_one_ov", n_ov, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
